// File: rtl/btb_assoc.sv
// btb_assoc: 2-way set-associative branch target buffer with 2-bit direction counters.
// Optional return-address stack is compiled in when macro BTB_RAS_EN is defined.
module btb_assoc #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 8,
  parameter int RAS_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] fetch_pc,
  output logic [31:0] pred_pc,
  output logic [1:0]  pred_taken,
  output logic        hit,
  input  logic        upd_valid,
  input  logic [31:0] fact_pc,
  input  logic [31:0] fact_tpc,
  input  logic [1:0]  fact_btype,
  input  logic        fact_taken,
  input  logic        predict_dir_fail,
  input  logic        predict_add_fail,
  input  logic        fact_call,
  input  logic        fact_ret,
  input  logic        flush
);

  localparam int SETS   = 1 << INDEX_WIDTH;
  localparam int TAG_LO = INDEX_WIDTH + 3;
  localparam int TAG_HI = INDEX_WIDTH + TAG_WIDTH + 2;

  logic                 valid_r [SETS][2];
  logic [TAG_WIDTH-1:0] tag_r   [SETS][2];
  logic [31:0]          tgt_r   [SETS][2];
  logic [1:0]           bt_r    [SETS][2];
  logic [1:0]           ctr_r   [SETS][2];
  logic                 lru_r   [SETS];

  logic [INDEX_WIDTH-1:0] lk_set_s;
  logic [TAG_WIDTH-1:0]   lk_tag_s;
  logic                   lk_h0_s, lk_h1_s, lk_way_s, lk_hit_s;
  logic [1:0]             lk_bt_s, lk_ctr_s, lk_pt_s;
  logic [31:0]            lk_tgt_s, lk_fall_s, lk_pc_s;

  logic [INDEX_WIDTH-1:0] up_set_s;
  logic [TAG_WIDTH-1:0]   up_tag_s;
  logic                   up_h0_s, up_h1_s, up_hit_s, up_way_s;
  logic [1:0]             ctr_old_s, ctr_nxt_s;
  logic                   do_hit_s, do_alloc_s, wr_data_s;

  logic [31:0]            ras_top_s;
  logic                   ras_ne_s;
  logic                   unused_s;

  // Lookup path: tag compare, direction decision and next-PC selection.
  always_comb begin
    lk_set_s  = fetch_pc[INDEX_WIDTH+2:3];
    lk_tag_s  = fetch_pc[TAG_HI:TAG_LO];
    lk_h0_s   = valid_r[lk_set_s][0] && (tag_r[lk_set_s][0] == lk_tag_s);
    lk_h1_s   = valid_r[lk_set_s][1] && (tag_r[lk_set_s][1] == lk_tag_s);
    lk_hit_s  = lk_h0_s || lk_h1_s;
    lk_way_s  = !lk_h0_s;
    lk_bt_s   = bt_r[lk_set_s][lk_way_s];
    lk_ctr_s  = ctr_r[lk_set_s][lk_way_s];
    lk_tgt_s  = tgt_r[lk_set_s][lk_way_s];
    lk_fall_s = fetch_pc[2] ? (fetch_pc + 32'd4) : (fetch_pc + 32'd8);
    if (lk_hit_s && ((lk_bt_s != 2'b10) || lk_ctr_s[1])) begin
      lk_pt_s = lk_bt_s;
    end else begin
      lk_pt_s = 2'b00;
    end
    if (lk_pt_s == 2'b00) begin
      lk_pc_s = lk_fall_s;
    end else if ((lk_pt_s == 2'b11) && ras_ne_s) begin
      lk_pc_s = ras_top_s;
    end else begin
      lk_pc_s = lk_tgt_s;
    end
  end

  assign hit        = lk_hit_s;
  assign pred_taken = lk_pt_s;
  assign pred_pc    = lk_pc_s;

  // Update path: hit detection, victim choice and saturating counter step.
  always_comb begin
    up_set_s = fact_pc[INDEX_WIDTH+2:3];
    up_tag_s = fact_pc[TAG_HI:TAG_LO];
    up_h0_s  = valid_r[up_set_s][0] && (tag_r[up_set_s][0] == up_tag_s);
    up_h1_s  = valid_r[up_set_s][1] && (tag_r[up_set_s][1] == up_tag_s);
    up_hit_s = up_h0_s || up_h1_s;
    if (up_h0_s) begin
      up_way_s = 1'b0;
    end else if (up_h1_s) begin
      up_way_s = 1'b1;
    end else if (!valid_r[up_set_s][0]) begin
      up_way_s = 1'b0;
    end else if (!valid_r[up_set_s][1]) begin
      up_way_s = 1'b1;
    end else begin
      up_way_s = lru_r[up_set_s];
    end
    ctr_old_s = ctr_r[up_set_s][up_way_s];
    if (fact_taken) begin
      ctr_nxt_s = (ctr_old_s == 2'b11) ? 2'b11 : (ctr_old_s + 2'd1);
    end else begin
      ctr_nxt_s = (ctr_old_s == 2'b00) ? 2'b00 : (ctr_old_s - 2'd1);
    end
    do_hit_s   = upd_valid && !flush && up_hit_s;
    do_alloc_s = upd_valid && !flush && !up_hit_s && fact_taken;
    wr_data_s  = do_alloc_s || (do_hit_s && fact_taken && predict_add_fail);
  end

  // Control state: valid, counters and LRU; flush clears valid/LRU ahead of updates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s][0] <= 1'b0;
        valid_r[s][1] <= 1'b0;
        ctr_r[s][0]   <= 2'b00;
        ctr_r[s][1]   <= 2'b00;
        lru_r[s]      <= 1'b0;
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s][0] <= 1'b0;
        valid_r[s][1] <= 1'b0;
        lru_r[s]      <= 1'b0;
      end
    end else if (do_hit_s) begin
      ctr_r[up_set_s][up_way_s] <= ctr_nxt_s;
      lru_r[up_set_s]           <= ~up_way_s;
    end else if (do_alloc_s) begin
      valid_r[up_set_s][up_way_s] <= 1'b1;
      ctr_r[up_set_s][up_way_s]   <= 2'b10;
      lru_r[up_set_s]             <= ~up_way_s;
    end
  end

  // Payload storage; meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (rstn && wr_data_s) begin
      tgt_r[up_set_s][up_way_s] <= fact_tpc;
      bt_r[up_set_s][up_way_s]  <= fact_btype;
    end
    if (rstn && do_alloc_s) begin
      tag_r[up_set_s][up_way_s] <= up_tag_s;
    end
  end

`ifdef BTB_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [31:0]   ras_r [RAS_DEPTH];
  logic [PW-1:0] ras_ptr_r;
  logic [PW:0]   ras_cnt_r;
  logic [PW-1:0] ras_top_idx_s;
  logic          push_s, pop_s;
  logic [31:0]   ret_addr_s;

  // Stack decode; ras_ptr_r points at the next free slot.
  always_comb begin
    push_s        = rstn && upd_valid && fact_call && !flush;
    pop_s         = rstn && upd_valid && fact_ret && !flush;
    ret_addr_s    = fact_pc + 32'd4;
    ras_top_idx_s = ras_ptr_r - PW'(1);
    ras_top_s     = ras_r[ras_top_idx_s];
    ras_ne_s      = (ras_cnt_r != '0);
  end

  // Stack pointer and occupancy; a full stack wraps onto its oldest entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ras_ptr_r <= '0;
      ras_cnt_r <= '0;
    end else if (flush) begin
      ras_ptr_r <= '0;
      ras_cnt_r <= '0;
    end else if (push_s && !pop_s) begin
      ras_ptr_r <= ras_ptr_r + PW'(1);
      if (ras_cnt_r != (PW+1)'(RAS_DEPTH)) begin
        ras_cnt_r <= ras_cnt_r + (PW+1)'(1);
      end
    end else if (pop_s && !push_s && ras_ne_s) begin
      ras_ptr_r <= ras_ptr_r - PW'(1);
      ras_cnt_r <= ras_cnt_r - (PW+1)'(1);
    end
  end

  // Stack entries; push with pop rewrites the current top in place.
  always_ff @(posedge clk) begin
    if (push_s && pop_s) begin
      ras_r[ras_top_idx_s] <= ret_addr_s;
    end else if (push_s) begin
      ras_r[ras_ptr_r] <= ret_addr_s;
    end
  end
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  assign ras_top_s = 32'h0000_0000;
  assign ras_ne_s  = 1'b0;
`endif

  // Direction-miss statistics, call/ret strobes and high PC bits feed no table state here.
  assign unused_s = ^{fact_pc, predict_dir_fail, fact_call, fact_ret};

endmodule
